rsa_modexp_core: RTL and testbench
==================================

# rsa_modexp_core

Parametrised modular-exponentiation engine (result = base^exp mod n) that serves both the encrypt (exp = e) and decrypt (exp = d) paths of the RSA datapath and replaces the separate fixed-width encrypt/decrypt blocks. It accepts one operation at a time over a valid/ready handshake and provides a runtime-selectable constant-time mode (always-multiply) for timing side-channel experiments. It also reports the cycle count of each operation.

## Interface
- WIDTH, 16, modulus/base/result width in bits (≥4)
- EXP_WIDTH, 16, exponent width in bits (≥1)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  core idle and able to accept
- base  in  WIDTH  message/ciphertext, must be < n
- exp  in  EXP_WIDTH  exponent (e or d)
- n  in  WIDTH  modulus, must be ≥ 2
- ct_mode  in  1  1 = constant-time square-and-always-multiply
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  base^exp mod n (0 on error)
- err  out  1  operand error flag, qualified by out_valid
- cycles  out  32  latency of the completed operation, qualified by out_valid
- busy  out  1  operation in progress (state SQR or MUL)

## Operation
- Reset: state IDLE; in_ready=1, out_valid=0, result=0, err=0, cycles=0, busy=0. A reset in any state aborts the operation and discards the result.
- Accept on in_valid && in_ready (cycle T). Capture base, exp, n, ct_mode. Later input changes are ignored.
- Error check at accept: if n<2 or base≥n, go to DONE with result=0, err=1, cycles=1.
- Otherwise: acc=1, bit index i=EXP_WIDTH-1. All EXP_WIDTH bits are scanned MSB→LSB, leading zeros included.
- States: IDLE → SQR → (MUL | SQR | DONE) … → DONE → IDLE.
- SQR: acc = acc·acc mod n. Then:
  - MUL if exp[i] or ct_mode;
  - otherwise decrement i, or go to DONE when i=0.
- MUL: product = acc·base mod n.
  - If exp[i]=1, write the product to acc.
  - If exp[i]=0 (ct_mode only), write it to a dummy register. acc is unchanged.
  - Then decrement i, or go to DONE when i=0.
- DONE: out_valid=1. result, err and cycles stay stable until out_ready. Return to IDLE on the cycle after the handshake.
- exp=0 gives result=1.
- Modular multiply uses MSB-first interleaved shift-add with a WIDTH+1-bit accumulator.
  - Per step: acc=2acc, subtract n if ≥n; then add the operand, subtract n if ≥n.
  - Both operands are < n, so no overflow occurs.

## Timing
- M = WIDTH+1 cycles per modular multiply (start to done, inclusive). There is no idle cycle between chained multiplies.
- out_valid rises at cycle T+L.
  - Normal mode: L = 1 + EXP_WIDTH·M + popcount(exp)·M.
  - ct_mode: L = 1 + 2·EXP_WIDTH·M, independent of exp.
  - Error: L = 1.
- cycles = L and is latched when DONE is entered.
- in_ready=0 from T+1 until the cycle after the output handshake. in_valid during this time is ignored and not queued.
- If out_valid and out_ready are both high, the handshake completes that cycle. in_ready=1 the following cycle.
- busy=1 exactly while in SQR or MUL.

## Structure
- Shared package rsa_pkg holds:
  - state encoding (IDLE, SQR, MUL, DONE);
  - the constant CYC_W=32;
  - the function mm_latency(WIDTH).
- One sub-module, rsa_modmul (parameter WIDTH): start/done pulse interface, operands a, b, n, product p. Latency is exactly M. p is held until the next start.
- The top FSM, exponent shift register, cycle counter and dummy register live in rsa_modexp_core.

## Test plan
- WIDTH=16, EXP_WIDTH=16, n=3233, exp=17, base=65, ct_mode=0 → result 2790, err 0, cycles 307.
- Same n, exp=2753, base=2790, ct_mode=0 → result 65, cycles 358. With ct_mode=1 → result 65, cycles 545. exp=17 with ct_mode=1 also gives cycles 545.
- exp=0, base=1234, n=3233 → result 1. base=3233 (≥n) or n=1 → err 1, result 0, cycles 1, out_valid at T+1.
- Hold out_ready=0 for 10 cycles after out_valid:
  - result, err and cycles are stable;
  - in_ready stays 0 and a concurrent in_valid is not accepted;
  - after out_ready=1, in_ready=1 on the next cycle.
- Assert rst mid-SQR → next cycle every output is at its reset value and in_ready=1. A subsequent exp=17 request gives 2790 with cycles 307.
- Random sweep (WIDTH=12, EXP_WIDTH=8): compare against a reference model. Check L against the normal-mode and ct_mode formulas per operation.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation datapath.
package rsa_pkg;

    localparam int CYC_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SQR,
        MUL,
        DONE
    } state_e;

    function automatic int mm_latency(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved shift-add modular multiplier, MSB-first, one operand bit per cycle.
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] n_i,
    output logic             done_o,
    output logic [WIDTH-1:0] p_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(mm_latency(WIDTH) - 2);

    logic [WIDTH-1:0] a_q, b_q, n_q, p_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q, done_q;

    function automatic logic [WIDTH-1:0] mm_step(
        input logic [WIDTH-1:0] p,
        input logic             bit_i,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] n
    );
        logic [WIDTH:0] t;
        t = {p, 1'b0};
        if (t >= {1'b0, n}) t = t - {1'b0, n};
        if (bit_i) t = t + {1'b0, b};
        if (t >= {1'b0, n}) t = t - {1'b0, n};
        return t[WIDTH-1:0];
    endfunction

    // The first step is folded into the start cycle so latency is WIDTH+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            n_q    <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                a_q   <= a_i << 1;
                b_q   <= b_i;
                n_q   <= n_i;
                p_q   <= mm_step('0, a_i[WIDTH-1], b_i, n_i);
                cnt_q <= CNT_INIT;
                run_q <= 1'b1;
            end else if (run_q) begin
                p_q   <= mm_step(p_q, a_q[WIDTH-1], b_q, n_q);
                a_q   <= a_q << 1;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;
    assign p_o    = p_q;

endmodule

// File: rtl/rsa_modexp_core.sv
// Left-to-right square-and-multiply modexp with optional always-multiply mode.
module rsa_modexp_core
    import rsa_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exp,
    input  logic [WIDTH-1:0]     n,
    input  logic                 ct_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 err,
    output logic [CYC_W-1:0]     cycles,
    output logic                 busy
);

    localparam int IW = $clog2(EXP_WIDTH + 1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d, base_q, base_d, n_q, n_d;
    logic [WIDTH-1:0]     res_q, res_d, unused_dummy_q, unused_dummy_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CYC_W-1:0]     cyc_q, cyc_d, cycles_q, cycles_d;
    logic                 ct_q, ct_d, err_q, err_d, start_q, start_d;
    logic                 step;
    logic                 mm_done;
    logic [WIDTH-1:0]     mm_p, mm_b;

    assign mm_b = (state_q == MUL) ? base_q : acc_q;

    rsa_modmul #(.WIDTH(WIDTH)) u_mm (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_q),
        .a_i     (acc_q),
        .b_i     (mm_b),
        .n_i     (n_q),
        .done_o  (mm_done),
        .p_o     (mm_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            base_q         <= '0;
            n_q            <= '0;
            res_q          <= '0;
            unused_dummy_q <= '0;
            exp_q          <= '0;
            idx_q          <= '0;
            cyc_q          <= '0;
            cycles_q       <= '0;
            ct_q           <= 1'b0;
            err_q          <= 1'b0;
            start_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            base_q         <= base_d;
            n_q            <= n_d;
            res_q          <= res_d;
            unused_dummy_q <= unused_dummy_d;
            exp_q          <= exp_d;
            idx_q          <= idx_d;
            cyc_q          <= cyc_d;
            cycles_q       <= cycles_d;
            ct_q           <= ct_d;
            err_q          <= err_d;
            start_q        <= start_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        base_d         = base_q;
        n_d            = n_q;
        res_d          = res_q;
        unused_dummy_d = unused_dummy_q;
        exp_d          = exp_q;
        idx_d          = idx_q;
        cyc_d          = cyc_q;
        cycles_d       = cycles_q;
        ct_d           = ct_q;
        err_d          = err_q;
        start_d        = 1'b0;
        step           = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    base_d = base;
                    exp_d  = exp;
                    n_d    = n;
                    ct_d   = ct_mode;
                    acc_d  = WIDTH'(1);
                    idx_d  = IW'(EXP_WIDTH - 1);
                    cyc_d  = CYC_W'(1);
                    if (n < WIDTH'(2) || base >= n) begin
                        state_d  = DONE;
                        res_d    = '0;
                        err_d    = 1'b1;
                        cycles_d = CYC_W'(1);
                    end else begin
                        state_d = SQR;
                        start_d = 1'b1;
                    end
                end
            end
            SQR: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (mm_done) begin
                    acc_d = mm_p;
                    if (exp_q[EXP_WIDTH-1] || ct_q) begin
                        state_d = MUL;
                        start_d = 1'b1;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            MUL: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (mm_done) begin
                    // Zero bits in constant-time mode burn the product on a dummy.
                    if (exp_q[EXP_WIDTH-1]) acc_d = mm_p;
                    else unused_dummy_d = mm_p;
                    step = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (step) begin
            if (idx_q == '0) begin
                state_d  = DONE;
                res_d    = acc_d;
                err_d    = 1'b0;
                cycles_d = cyc_q + CYC_W'(1);
            end else begin
                idx_d   = idx_q - IW'(1);
                exp_d   = exp_q << 1;
                state_d = SQR;
                start_d = 1'b1;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SQR) || (state_q == MUL);
    assign result    = res_q;
    assign err       = err_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Scoreboard bench: directed RSA vectors on a 16/16 core, random sweep on a 12/8 core.
module tb_rsa_modexp_core;
    import rsa_pkg::*;

    typedef struct {
        longint res;
        longint err;
        longint cyc;
        longint t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic             rv0 = 0, rdy0, ct0 = 0, ov0, ordy0 = 1, err0, busy0;
    logic [15:0]      b0 = 0, e0 = 0, n0 = 0, res0;
    logic [CYC_W-1:0] cy0;
    logic             rv1 = 0, rdy1, ct1 = 0, ov1, ordy1 = 1, err1, busy1;
    logic [11:0]      b1 = 0, n1 = 0, res1;
    logic [7:0]       e1 = 0;
    logic [CYC_W-1:0] cy1;
    bit               rnd1 = 0;

    exp_t q0[$];
    exp_t q1[$];

    rsa_modexp_core #(.WIDTH(16), .EXP_WIDTH(16)) u0 (
        .clk(clk), .rst(rst), .in_valid(rv0), .in_ready(rdy0),
        .base(b0), .exp(e0), .n(n0), .ct_mode(ct0),
        .out_valid(ov0), .out_ready(ordy0), .result(res0),
        .err(err0), .cycles(cy0), .busy(busy0)
    );

    rsa_modexp_core #(.WIDTH(12), .EXP_WIDTH(8)) u1 (
        .clk(clk), .rst(rst), .in_valid(rv1), .in_ready(rdy1),
        .base(b1), .exp(e1), .n(n1), .ct_mode(ct1),
        .out_valid(ov1), .out_ready(ordy1), .result(res1),
        .err(err1), .cycles(cy1), .busy(busy1)
    );

    task automatic chk(input string nm, input longint act, input longint exv);
        checks++;
        if (act !== exv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exv);
        end
    endtask

    function automatic exp_t model(input longint b, input longint e, input longint nn,
                                   input bit ct, input int w, input int ew);
        exp_t m;
        longint r;
        int pc;
        m.t = 0;
        if (nn < 2 || b >= nn) begin
            m.res = 0;
            m.err = 1;
            m.cyc = 1;
        end else begin
            r = 1;
            pc = 0;
            for (int i = ew - 1; i >= 0; i--) begin
                r = (r * r) % nn;
                if (((e >> i) & 1) == 1) begin
                    r = (r * b) % nn;
                    pc++;
                end
            end
            m.res = r;
            m.err = 0;
            m.cyc = 1 + ew * (w + 1) + (ct ? ew : pc) * (w + 1);
        end
        return m;
    endfunction

    // Monitors: compare each output handshake against the head of the queue.
    bit pv0 = 0, pv1 = 0;
    int rise0 = 0, rise1 = 0;
    always @(negedge clk) begin
        if (rst) begin
            pv0 = 0;
        end else begin
            if (ov0 && !pv0) rise0 = cyc;
            pv0 = ov0;
            if (ov0 && ordy0) begin
                if (q0.size() == 0) begin
                    chk("u0_unexpected_output", 1, 0);
                end else begin
                    exp_t x;
                    x = q0.pop_front();
                    chk("u0_result", longint'(res0), x.res);
                    chk("u0_err", longint'(err0), x.err);
                    chk("u0_cycles", longint'(cy0), x.cyc);
                    chk("u0_latency", longint'(rise0) - x.t, x.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pv1 = 0;
        end else begin
            if (ov1 && !pv1) rise1 = cyc;
            pv1 = ov1;
            if (ov1 && ordy1) begin
                if (q1.size() == 0) begin
                    chk("u1_unexpected_output", 1, 0);
                end else begin
                    exp_t x;
                    x = q1.pop_front();
                    chk("u1_result", longint'(res1), x.res);
                    chk("u1_err", longint'(err1), x.err);
                    chk("u1_cycles", longint'(cy1), x.cyc);
                    chk("u1_latency", longint'(rise1) - x.t, x.cyc);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        ordy1 = rnd1 ? 1'($urandom) : 1'b1;
    end

    task automatic issue0(input longint b, input longint e, input longint nn, input bit ct,
                          input longint xr, input longint xe, input longint xc, input bit push);
        int k = 0;
        while (!rdy0 && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
        if (!rdy0) begin
            chk("u0_accept_timeout", 0, 1);
            return;
        end
        rv0 = 1; b0 = 16'(b); e0 = 16'(e); n0 = 16'(nn); ct0 = ct;
        if (push) q0.push_back('{res: xr, err: xe, cyc: xc, t: longint'(cyc)});
        @(posedge clk); #1;
        rv0 = 0; b0 = 16'($urandom); e0 = 16'($urandom); n0 = 16'($urandom);
    endtask

    task automatic issue1(input longint b, input longint e, input longint nn, input bit ct);
        int k = 0;
        exp_t m;
        while (!rdy1 && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
        if (!rdy1) begin
            chk("u1_accept_timeout", 0, 1);
            return;
        end
        m = model(b, e, nn, ct, 12, 8);
        m.t = cyc;
        rv1 = 1; b1 = 12'(b); e1 = 8'(e); n1 = 12'(nn); ct1 = ct;
        q1.push_back(m);
        @(posedge clk); #1;
        rv1 = 0; b1 = 12'($urandom); e1 = 8'($urandom);
    endtask

    task automatic drain();
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 20000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_q0_timeout", q0.size(), 0);
        chk("drain_q1_timeout", q1.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, rdy0, 1);
        chk({tag, "_out_valid"}, ov0, 0);
        chk({tag, "_result"}, res0, 0);
        chk({tag, "_err"}, err0, 0);
        chk({tag, "_cycles"}, cy0, 0);
        chk({tag, "_busy"}, busy0, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst0");
        rst = 0;

        issue0(65, 17, 3233, 0, 2790, 0, 307, 1);
        issue0(2790, 2753, 3233, 0, 65, 0, 358, 1);
        issue0(2790, 2753, 3233, 1, 65, 0, 545, 1);
        issue0(65, 17, 3233, 1, 2790, 0, 545, 1);
        issue0(1234, 0, 3233, 0, 1, 0, 273, 1);
        issue0(3233, 17, 3233, 0, 0, 1, 1, 1);
        issue0(5, 17, 1, 0, 0, 1, 1, 1);
        drain();

        // Back-pressure: hold out_ready low for 10 cycles after out_valid.
        ordy0 = 0;
        issue0(65, 17, 3233, 0, 2790, 0, 307, 1);
        begin
            int k = 0;
            while (!ov0 && k < 1000) begin
                @(posedge clk); #1;
                k++;
            end
            chk("hold_valid_timeout", ov0, 1);
        end
        rv0 = 1; b0 = 7; e0 = 3; n0 = 11; ct0 = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_result", res0, 2790);
            chk("hold_err", err0, 0);
            chk("hold_cycles", cy0, 307);
            chk("hold_in_ready", rdy0, 0);
            chk("hold_out_valid", ov0, 1);
        end
        rv0 = 0;
        ordy0 = 1;
        @(posedge clk); #1;
        chk("post_hs_in_ready", rdy0, 1);
        chk("post_hs_out_valid", ov0, 0);

        // Abort mid-operation with reset.
        issue0(65, 17, 3233, 0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", busy0, 1);
        rst = 1;
        @(posedge clk); #1;
        q0.delete();
        chk_reset_outputs("rst1");
        rst = 0;
        issue0(65, 17, 3233, 0, 2790, 0, 307, 1);
        drain();

        rnd1 = 1;
        issue1(200, 255, 4093, 0);
        issue1(200, 0, 4093, 1);
        issue1(4094, 5, 4093, 0);
        for (int i = 0; i < 40; i++) begin
            int nn, b, e;
            bit ct;
            nn = ($urandom % 8 == 0) ? int'($urandom_range(1, 0)) : int'($urandom_range(4095, 2));
            if (nn == 0 || $urandom % 8 == 0) b = int'($urandom_range(4095, nn));
            else b = int'($urandom_range(nn - 1, 0));
            e = int'($urandom_range(255, 0));
            ct = 1'($urandom);
            issue1(b, e, nn, ct);
        end
        drain();
        rnd1 = 0;

        repeat (30) @(posedge clk);
        #1;
        chk("final_q0_empty", q0.size(), 0);
        chk("final_q1_empty", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
